reg_wb_queue: RTL and testbench

Writeback sequencer that drives the single write port of the 64-bit, 32-entry register file (x0 hardwired to zero). It merges two result producers: the in-order pipeline writeback, which can never stall, and a long-latency unit (multiply/divide), which uses a valid/ready handshake. Long-latency results are buffered in a small FIFO and issued into idle write-port cycles. A lookup port lets decode forward values that are queued or in flight and not yet committed to the register file.

---
 rtl/reg_wb_queue.sv | 104 ++++++++++
 tb/tb_reg_wb_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// Register-file writeback sequencer: pipeline results win the write port, long-latency results queue and fill idle cycles.
// Latency: pipeline 1 cycle to the output stage; an uncontended long-latency result 2 cycles (push, then pop).
// Backpressure: pipeline never stalls; m_ready drops only while the FIFO holds DEPTH entries.
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            p_valid,
    input  logic [4:0]      p_rd,
    input  logic [XLEN-1:0] p_data,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic [4:0]      m_rd,
    input  logic [XLEN-1:0] m_data,
    output logic [4:0]      rd,
    output logic            write,
    output logic [XLEN-1:0] write_data,
    input  logic [4:0]      lookup_rs,
    output logic            lookup_hit,
    output logic [XLEN-1:0] lookup_data,
    output logic            drained
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]      q_rd  [DEPTH];
    logic [XLEN-1:0] q_dat [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            p_take;
    logic            push;
    logic            pop;

    // Full is judged on the registered count alone, so a full FIFO refuses a push even while popping.
    assign m_ready = (count != FULL) && rstn;
    assign p_take  = p_valid && (p_rd != 5'd0);
    assign pop     = !p_take && (count != '0);
    assign push    = m_valid && m_ready && (m_rd != 5'd0);
    assign drained = (count == '0) && !write;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]  <= m_rd;
            q_dat[tail] <= m_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write      <= 1'b0;
            rd         <= 5'd0;
            write_data <= '0;
        end else begin
            write <= p_take || pop;
            if (p_take) begin
                rd         <= p_rd;
                write_data <= p_data;
            end else if (pop) begin
                rd         <= q_rd[head];
                write_data <= q_dat[head];
            end
        end
    end

    // Output stage is lowest priority; FIFO is scanned oldest to youngest so the youngest match wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        if (lookup_rs != 5'd0) begin
            if (write && (rd == lookup_rs)) begin
                lookup_hit  = 1'b1;
                lookup_data = write_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count) && (q_rd[head + AW'(i)] == lookup_rs)) begin
                    lookup_hit  = 1'b1;
                    lookup_data = q_dat[head + AW'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: priority, FIFO backpressure, x0 handling, lookup, wrap-around and async reset.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic            p_valid;
    logic [4:0]      p_rd;
    logic [XLEN-1:0] p_data;
    logic            m_valid;
    logic            m_ready;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    logic [4:0]      rd;
    logic            write;
    logic [XLEN-1:0] write_data;
    logic [4:0]      lookup_rs;
    logic            lookup_hit;
    logic [XLEN-1:0] lookup_data;
    logic            drained;

    int n_chk  = 0;
    int n_pass = 0;

    logic [4:0]      log_rd[$];
    logic [XLEN-1:0] log_dat[$];
    logic [4:0]      exp_rd[$];
    logic [XLEN-1:0] exp_dat[$];

    reg_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
        .rd(rd), .write(write), .write_data(write_data),
        .lookup_rs(lookup_rs), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .drained(drained)
    );

    always #5 clk = ~clk;

    // A write visible mid-cycle commits at the next posedge unless reset intervenes first.
    always @(negedge clk) begin
        if (rstn && write) begin
            log_rd.push_back(rd);
            log_dat.push_back(write_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        int k;
        int budget;
        int m_idx;
        rstn = 1'b0; p_valid = 1'b0; p_rd = '0; p_data = '0;
        m_valid = 1'b0; m_rd = '0; m_data = '0; lookup_rs = 5'd5;
        #2;
        check("rst_write", write, 1'b0);
        check("rst_rd", rd, 5'd0);
        check("rst_wdata", write_data, 64'd0);
        check("rst_m_ready", m_ready, 1'b0);
        check("rst_hit", lookup_hit, 1'b0);
        check("rst_ldata", lookup_data, 64'd0);
        check("rst_drained", drained, 1'b1);
        step();
        rstn = 1'b1;
        #1;
        check("post_rst_m_ready", m_ready, 1'b1);

        // single pipeline write
        p_valid = 1'b1; p_rd = 5'd5; p_data = 64'hDEAD;
        step();
        check("p_write", write, 1'b1);
        check("p_rd", rd, 5'd5);
        check("p_wdata", write_data, 64'hDEAD);
        check("p_lookup_hit", lookup_hit, 1'b1);
        check("p_lookup_data", lookup_data, 64'hDEAD);
        idle();
        step();
        check("p_idle_write", write, 1'b0);
        check("p_idle_rd_hold", rd, 5'd5);
        check("p_idle_drained", drained, 1'b1);

        // FIFO fill under continuous pipeline writes
        for (int i = 0; i < DEPTH; i++) begin
            p_valid = 1'b1; p_rd = 5'(1 + i); p_data = 64'(100 + i);
            m_valid = 1'b1; m_rd = 5'(10 + i); m_data = 64'(8'hA0 + i);
            check("fill_m_ready", m_ready, 1'b1);
            step();
            check("fill_rd", rd, 5'(1 + i));
        end
        m_valid = 1'b0;
        check("full_m_ready", m_ready, 1'b0);
        check("full_drained", drained, 1'b0);
        p_rd = 5'd5;
        step();
        check("full_hold_m_ready", m_ready, 1'b0);
        check("full_hold_rd", rd, 5'd5);
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check("drain_write", write, 1'b1);
            check("drain_rd", rd, 5'(10 + i));
            check("drain_wdata", write_data, 64'(8'hA0 + i));
            if (i == 0) check("drain_m_ready", m_ready, 1'b1);
        end
        check("drain_last_drained", drained, 1'b0);
        step();
        check("drain_done_write", write, 1'b0);
        check("drain_done_drained", drained, 1'b1);

        // x0 handling
        m_valid = 1'b1; m_rd = 5'd3; m_data = 64'h33;
        step();
        check("x0_queued_write", write, 1'b0);
        check("x0_queued_drained", drained, 1'b0);
        p_valid = 1'b1; p_rd = 5'd0; p_data = 64'hBAD;
        m_valid = 1'b1; m_rd = 5'd0; m_data = 64'hBAD;
        check("x0_m_ready", m_ready, 1'b1);
        step();
        check("x0_pop_write", write, 1'b1);
        check("x0_pop_rd", rd, 5'd3);
        check("x0_pop_wdata", write_data, 64'h33);
        m_valid = 1'b0;
        step();
        check("x0_p_write", write, 1'b0);
        check("x0_drained", drained, 1'b1);
        idle();

        // lookup: two writes to x7 held in the FIFO by pipeline traffic
        p_valid = 1'b1; p_rd = 5'd20; p_data = 64'h200;
        m_valid = 1'b1; m_rd = 5'd7; m_data = 64'h11;
        step();
        p_rd = 5'd21; p_data = 64'h210;
        m_data = 64'h22;
        step();
        idle();
        lookup_rs = 5'd7; #1;
        check("lk_young_hit", lookup_hit, 1'b1);
        check("lk_young_data", lookup_data, 64'h22);
        lookup_rs = 5'd21; #1;
        check("lk_out_hit", lookup_hit, 1'b1);
        check("lk_out_data", lookup_data, 64'h210);
        lookup_rs = 5'd0; #1;
        check("lk_x0_hit", lookup_hit, 1'b0);
        check("lk_x0_data", lookup_data, 64'd0);
        lookup_rs = 5'd7;
        step();
        check("lk_fifo_over_out", lookup_data, 64'h22);
        step();
        check("lk_out_only_hit", lookup_hit, 1'b1);
        check("lk_out_only_data", lookup_data, 64'h22);
        step();
        check("lk_commit_hit", lookup_hit, 1'b0);
        check("lk_commit_data", lookup_data, 64'd0);

        // wrap-around: 3*DEPTH pushes with occasional pipeline stalls of the drain
        log_rd.delete(); log_dat.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            p_valid = (i % 4 == 0); p_rd = 5'd25; p_data = 64'h25;
            m_valid = 1'b1; m_rd = 5'(1 + i); m_data = {$urandom, $urandom};
            if (m_ready) begin
                exp_rd.push_back(m_rd);
                exp_dat.push_back(m_data);
            end
            step();
        end
        idle();
        budget = 0;
        while (!drained && budget < 40) begin
            step();
            budget++;
        end
        if (budget >= 40) check("wrap_drain_timeout", 1'b0, 1'b1);
        check("wrap_accepted", exp_rd.size(), 3 * DEPTH);
        m_idx = 0;
        for (int i = 0; i < log_rd.size(); i++) begin
            if (log_rd[i] != 5'd25) begin
                if (m_idx < exp_rd.size()) begin
                    check("wrap_rd", log_rd[i], exp_rd[m_idx]);
                    check("wrap_data", log_dat[i], exp_dat[m_idx]);
                end
                m_idx++;
            end
        end
        check("wrap_commits", m_idx, exp_rd.size());

        // asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            p_valid = 1'b1; p_rd = 5'(17 + i); p_data = 64'h1700;
            m_valid = 1'b1; m_rd = 5'(14 + i); m_data = 64'(8'hE0 + i);
            step();
        end
        idle();
        check("pre_rst_write", write, 1'b1);
        check("pre_rst_drained", drained, 1'b0);
        log_rd.delete(); log_dat.delete();
        rstn = 1'b0;
        #1;
        check("mid_rst_write", write, 1'b0);
        check("mid_rst_drained", drained, 1'b1);
        check("mid_rst_m_ready", m_ready, 1'b0);
        lookup_rs = 5'd14; #0;
        check("mid_rst_hit", lookup_hit, 1'b0);
        #1;
        rstn = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (write) k++;
        end
        check("post_rst_no_writes", k, 0);
        check("post_rst_log", log_rd.size(), 0);
        check("post_rst_drained", drained, 1'b1);
        check("post_rst_ready", m_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
